// File: rtl/healthcare_pkg.sv
// rtl/healthcare_pkg.sv - shared constants, field widths and state encoding for the sensor frame receiver
package healthcare_pkg;

    localparam logic [7:0] HEADER_BYTE_DEFAULT = 8'hA5;

    localparam int BYTE_PRESSURE     = 1;
    localparam int BYTE_BLOOD        = 2;
    localparam int BYTE_FD_SENSOR    = 3;
    localparam int BYTE_FD_FACTORY   = 4;
    localparam int BYTE_BLOOD_SENSOR = 5;
    localparam int BYTE_BASE_TEMP    = 6;
    localparam int BYTE_TEMP         = 7;
    localparam int BYTE_CHECKSUM     = 8;

    localparam int W_PRESSURE     = 6;
    localparam int W_BLOOD_PH     = 4;
    localparam int W_BLOOD_TYPE   = 3;
    localparam int W_FD_SENSOR    = 8;
    localparam int W_FD_FACTORY   = 8;
    localparam int W_BLOOD_SENSOR = 8;
    localparam int W_BASE_TEMP    = 8;
    localparam int W_TEMP_COEF    = 4;
    localparam int W_TEMP_SENSOR  = 4;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_CHECKSUM = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b10;

    typedef enum logic [1:0] {
        ST_HUNT    = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_COMMIT  = 2'd2
    } rx_state_t;

    function automatic logic [7:0] payload_xor(input logic [7:1][7:0] bytes);
        logic [7:0] acc;
        acc = 8'h00;
        for (int i = 1; i <= 7; i++) begin
            acc = acc ^ bytes[i];
        end
        return acc;
    endfunction

endpackage

// File: rtl/byte_timeout_timer.sv
// rtl/byte_timeout_timer.sv - idle-cycle counter that flags expiry after TIMEOUT_CYCLES-1 quiet cycles
module byte_timeout_timer #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int CW = $clog2(TIMEOUT_CYCLES);

    logic [CW-1:0] r_count;
    logic          w_at_max;

    assign w_at_max  = (r_count == CW'(TIMEOUT_CYCLES - 1));
    assign o_expired = i_enable && w_at_max;

    // Holds at the limit; the owner clears it once it has acted on expiry.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && !w_at_max) begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

// File: rtl/sensor_frame_receiver.sv
// rtl/sensor_frame_receiver.sv - frames header/7-byte/XOR sensor stream into parallel fields; SENSOR_RX_STATS_EN adds frame counters
module sensor_frame_receiver
    import healthcare_pkg::*;
#(
    parameter logic [7:0] HEADER_BYTE    = HEADER_BYTE_DEFAULT,
    parameter int         TIMEOUT_CYCLES = 255
) (
    input  logic                      clk,
    input  logic                      rstN,
    input  logic                      inValid,
    input  logic [7:0]                inData,
    output logic                      inReady,
    output logic [W_PRESSURE-1:0]     pressureData,
    output logic [W_BLOOD_PH-1:0]     bloodPH,
    output logic [W_BLOOD_TYPE-1:0]   bloodType,
    output logic [W_FD_SENSOR-1:0]    fdSensorValue,
    output logic [W_FD_FACTORY-1:0]   fdFactoryValue,
    output logic [W_BLOOD_SENSOR-1:0] bloodSensor,
    output logic [W_BASE_TEMP-1:0]    factoryBaseTemp,
    output logic [W_TEMP_COEF-1:0]    factoryTempCoef,
    output logic [W_TEMP_SENSOR-1:0]  tempSensorValue,
`ifdef SENSOR_RX_STATS_EN
    output logic [15:0]               goodFrames,
    output logic [15:0]               badFrames,
`endif
    output logic                      frameValid,
    output logic                      frameError,
    output logic [1:0]                errCode
);

    rx_state_t        r_state;
    logic [3:0]       r_idx;
    logic [8:1][7:0]  r_frame;
    logic             r_in_ready;
    logic             w_xfer;
    logic             w_expired;
    logic             w_sum_ok;

    assign inReady  = r_in_ready;
    assign w_xfer   = inValid && r_in_ready;
    assign w_sum_ok = (payload_xor(r_frame[7:1]) == r_frame[BYTE_CHECKSUM]);

    byte_timeout_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .i_clk    (clk),
        .i_rst_n  (rstN),
        .i_clear  (w_xfer || (r_state != ST_PAYLOAD)),
        .i_enable (r_state == ST_PAYLOAD),
        .o_expired(w_expired)
    );

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_state         <= ST_HUNT;
            r_idx           <= '0;
            r_frame         <= '0;
            r_in_ready      <= 1'b1;
            pressureData    <= '0;
            bloodPH         <= '0;
            bloodType       <= '0;
            fdSensorValue   <= '0;
            fdFactoryValue  <= '0;
            bloodSensor     <= '0;
            factoryBaseTemp <= '0;
            factoryTempCoef <= '0;
            tempSensorValue <= '0;
            frameValid      <= 1'b0;
            frameError      <= 1'b0;
            errCode         <= ERR_NONE;
`ifdef SENSOR_RX_STATS_EN
            goodFrames      <= '0;
            badFrames       <= '0;
`endif
        end else begin
            frameValid <= 1'b0;
            frameError <= 1'b0;
            case (r_state)
                ST_HUNT: begin
                    if (w_xfer && (inData == HEADER_BYTE)) begin
                        r_state <= ST_PAYLOAD;
                        r_idx   <= 4'd1;
                    end
                end
                ST_PAYLOAD: begin
                    // A byte arriving on the expiry cycle takes priority over the abort.
                    if (w_xfer) begin
                        r_frame[r_idx] <= inData;
                        if (r_idx == 4'(BYTE_CHECKSUM)) begin
                            r_state    <= ST_COMMIT;
                            r_in_ready <= 1'b0;
                        end else begin
                            r_idx <= r_idx + 4'd1;
                        end
                    end else if (w_expired) begin
                        r_state    <= ST_HUNT;
                        frameError <= 1'b1;
                        errCode    <= ERR_TIMEOUT;
`ifdef SENSOR_RX_STATS_EN
                        if (badFrames != 16'hFFFF) badFrames <= badFrames + 16'd1;
`endif
                    end
                end
                ST_COMMIT: begin
                    r_state    <= ST_HUNT;
                    r_in_ready <= 1'b1;
                    if (w_sum_ok) begin
                        pressureData    <= r_frame[BYTE_PRESSURE][W_PRESSURE-1:0];
                        bloodPH         <= r_frame[BYTE_BLOOD][7:4];
                        bloodType       <= r_frame[BYTE_BLOOD][2:0];
                        fdSensorValue   <= r_frame[BYTE_FD_SENSOR];
                        fdFactoryValue  <= r_frame[BYTE_FD_FACTORY];
                        bloodSensor     <= r_frame[BYTE_BLOOD_SENSOR];
                        factoryBaseTemp <= r_frame[BYTE_BASE_TEMP];
                        factoryTempCoef <= r_frame[BYTE_TEMP][7:4];
                        tempSensorValue <= r_frame[BYTE_TEMP][3:0];
                        frameValid      <= 1'b1;
`ifdef SENSOR_RX_STATS_EN
                        if (goodFrames != 16'hFFFF) goodFrames <= goodFrames + 16'd1;
`endif
                    end else begin
                        frameError <= 1'b1;
                        errCode    <= ERR_CHECKSUM;
`ifdef SENSOR_RX_STATS_EN
                        if (badFrames != 16'hFFFF) badFrames <= badFrames + 16'd1;
`endif
                    end
                end
                default: begin
                    r_state    <= ST_HUNT;
                    r_in_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sensor_frame_receiver.sv
// tb/tb_sensor_frame_receiver.sv - randomized and directed self-checking bench for sensor_frame_receiver
module tb_sensor_frame_receiver;

    localparam logic [7:0] HDR = 8'hA5;
    localparam int         TMO = 255;

    logic       clk = 1'b0;
    logic       rstN = 1'b0;
    logic       inValid = 1'b0;
    logic [7:0] inData = 8'h00;
    logic       inReady;
    logic [5:0] pressureData;
    logic [3:0] bloodPH;
    logic [2:0] bloodType;
    logic [7:0] fdSensorValue, fdFactoryValue, bloodSensor, factoryBaseTemp;
    logic [3:0] factoryTempCoef, tempSensorValue;
    logic       frameValid, frameError;
    logic [1:0] errCode;
`ifdef SENSOR_RX_STATS_EN
    logic [15:0] goodFrames, badFrames;
`endif

    always #5 clk = ~clk;

    sensor_frame_receiver #(.HEADER_BYTE(HDR), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rstN(rstN), .inValid(inValid), .inData(inData), .inReady(inReady),
        .pressureData(pressureData), .bloodPH(bloodPH), .bloodType(bloodType),
        .fdSensorValue(fdSensorValue), .fdFactoryValue(fdFactoryValue),
        .bloodSensor(bloodSensor), .factoryBaseTemp(factoryBaseTemp),
        .factoryTempCoef(factoryTempCoef), .tempSensorValue(tempSensorValue),
`ifdef SENSOR_RX_STATS_EN
        .goodFrames(goodFrames), .badFrames(badFrames),
`endif
        .frameValid(frameValid), .frameError(frameError), .errCode(errCode)
    );

    int         n_checks = 0;
    int         n_fail = 0;
    logic [7:0] q[$];
    int         idle;
    logic [7:0] m_f[1:7];
    bit         e_fv, e_fe, e_ready;
    logic [1:0] e_err;
    int         e_good, e_bad;
    logic [7:0] frame_a[7] = '{8'h21, 8'h81, 8'h0A, 8'h0A, 8'h10, 8'h1E, 8'h42};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        idle = 0;
        for (int i = 1; i <= 7; i++) m_f[i] = 8'h00;
        e_fv = 0; e_fe = 0; e_err = 2'b00; e_ready = 1;
        e_good = 0; e_bad = 0;
    endtask

    // Frame-level view: a frame is the list of bytes collected since the header; 9 bytes means verdict pending.
    task automatic model_step(input bit v, input logic [7:0] d);
        logic [7:0] x;
        e_fv = 0; e_fe = 0;
        if (q.size() == 9) begin
            x = 8'h00;
            for (int i = 1; i <= 7; i++) x ^= q[i];
            if (x == q[8]) begin
                for (int i = 1; i <= 7; i++) m_f[i] = q[i];
                e_fv = 1;
                if (e_good < 65535) e_good++;
            end else begin
                e_fe = 1; e_err = 2'b01;
                if (e_bad < 65535) e_bad++;
            end
            q.delete();
        end else if (q.size() == 0) begin
            if (v && d == HDR) begin q.push_back(d); idle = 0; end
        end else if (v) begin
            q.push_back(d); idle = 0;
        end else if (idle == TMO - 1) begin
            e_fe = 1; e_err = 2'b10;
            if (e_bad < 65535) e_bad++;
            q.delete(); idle = 0;
        end else begin
            idle++;
        end
        e_ready = (q.size() != 9);
    endtask

    task automatic check_all();
        logic [7:0] b1, b2, b7;
        b1 = m_f[1]; b2 = m_f[2]; b7 = m_f[7];
        chk("inReady", inReady, e_ready);
        chk("frameValid", frameValid, e_fv);
        chk("frameError", frameError, e_fe);
        chk("errCode", errCode, e_err);
        chk("pressureData", pressureData, b1[5:0]);
        chk("bloodPH", bloodPH, b2[7:4]);
        chk("bloodType", bloodType, b2[2:0]);
        chk("fdSensorValue", fdSensorValue, m_f[3]);
        chk("fdFactoryValue", fdFactoryValue, m_f[4]);
        chk("bloodSensor", bloodSensor, m_f[5]);
        chk("factoryBaseTemp", factoryBaseTemp, m_f[6]);
        chk("factoryTempCoef", factoryTempCoef, b7[7:4]);
        chk("tempSensorValue", tempSensorValue, b7[3:0]);
        if (frameValid && frameError) chk("pulse_exclusive", 1, 0);
`ifdef SENSOR_RX_STATS_EN
        chk("goodFrames", goodFrames, e_good);
        chk("badFrames", badFrames, e_bad);
`endif
    endtask

    task automatic cycle(input bit v, input logic [7:0] d);
        inValid = v; inData = d;
        model_step(v, d);
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic send(input logic [7:0] b);
        bit took;
        took = 0;
        for (int k = 0; k < 4 && !took; k++) begin
            took = (q.size() != 9);
            cycle(1, b);
        end
        if (!took) chk("send_accept", 0, 1);
        inValid = 0;
    endtask

    task automatic send_frame(input logic [7:0] p[7], input bit good, input int maxgap);
        logic [7:0] x;
        x = 8'h00;
        send(HDR);
        for (int i = 0; i < 7; i++) begin
            x ^= p[i];
            repeat ($urandom_range(0, maxgap)) cycle(0, 8'h00);
            send(p[i]);
        end
        send(good ? x : (x ^ 8'(1 << $urandom_range(0, 7))));
    endtask

    task automatic async_reset();
        #2 rstN = 0;
        #1;
        chk("rst_pressure", pressureData, 0);
        chk("rst_bloodSensor", bloodSensor, 0);
        chk("rst_tempSensor", tempSensorValue, 0);
        chk("rst_frameValid", frameValid, 0);
        chk("rst_frameError", frameError, 0);
        chk("rst_errCode", errCode, 0);
        model_reset();
        @(negedge clk);
        check_all();
        rstN = 1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] p[7];
        model_reset();
        repeat (2) @(negedge clk);
        check_all();
        rstN = 1;
        cycle(0, 8'h00);

        // reference frame from the plan, then the literal decode
        send_frame(frame_a, 1, 0);
        cycle(0, 8'h00);
        chk("lit_frameValid", frameValid, 1);
        chk("lit_pressure", pressureData, 6'b100001);
        chk("lit_bloodPH", bloodPH, 8);
        chk("lit_bloodType", bloodType, 1);
        chk("lit_fdSensor", fdSensorValue, 10);
        chk("lit_fdFactory", fdFactoryValue, 10);
        chk("lit_bloodSensor", bloodSensor, 16);
        chk("lit_baseTemp", factoryBaseTemp, 30);
        chk("lit_tempCoef", factoryTempCoef, 4);
        chk("lit_tempSensor", tempSensorValue, 2);

        // same payload with checksum ED
        send(HDR);
        for (int i = 0; i < 7; i++) send(frame_a[i]);
        send(8'hED);
        cycle(0, 8'h00);
        chk("lit_cs_frameError", frameError, 1);
        chk("lit_cs_errCode", errCode, 2'b01);
        chk("lit_cs_pressure_kept", pressureData, 6'b100001);
`ifdef SENSOR_RX_STATS_EN
        chk("lit_good1", goodFrames, 1);
        chk("lit_bad1", badFrames, 1);
`endif

        // garbage ahead of a good frame
        send(8'h00); send(8'hFF); send(8'hA4);
        send_frame(frame_a, 1, 1);
        cycle(0, 8'h00);
        chk("lit_garbage_valid", frameValid, 1);

        // inter-byte timeout
        send(HDR); send(8'h21); send(8'h81);
        repeat (TMO) cycle(0, 8'h00);
        chk("lit_tmo_frameError", frameError, 1);
        chk("lit_tmo_errCode", errCode, 2'b10);
        cycle(0, 8'h00);
        chk("lit_tmo_ready", inReady, 1);
        send_frame(frame_a, 1, 0);
        cycle(0, 8'h00);
        chk("lit_after_tmo_valid", frameValid, 1);

        // byte on the expiry cycle is accepted
        send(HDR); send(8'h21); send(8'h81);
        repeat (TMO - 1) cycle(0, 8'h00);
        for (int i = 2; i < 7; i++) send(frame_a[i]);
        send(8'hEC);
        cycle(0, 8'h00);
        chk("lit_expiry_valid", frameValid, 1);
        chk("lit_expiry_errCode", errCode, 2'b10);

        // async reset mid-frame
        send(HDR); send(8'h21); send(8'h81); send(8'h0A);
        async_reset();
        cycle(0, 8'h00);
        send_frame(frame_a, 1, 0);
        cycle(0, 8'h00);
        chk("lit_post_reset_valid", frameValid, 1);
        chk("lit_post_reset_errCode", errCode, 2'b00);

        // randomized traffic
        for (int f = 0; f < 40; f++) begin
            repeat ($urandom_range(0, 2)) send(8'($urandom_range(0, 255)));
            for (int i = 0; i < 7; i++) p[i] = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 9) == 0) begin
                send(HDR);
                repeat ($urandom_range(1, 4)) send(8'($urandom_range(0, 255)));
                repeat (TMO + $urandom_range(0, 3)) cycle(0, 8'h00);
            end
            send_frame(p, $urandom_range(0, 3) != 0, 3);
            repeat ($urandom_range(0, 2)) cycle(0, 8'h00);
        end
        repeat (3) cycle(0, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
